alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue and writeback stage that sits directly upstream of the ALU.
- Accepts one 16-bit ALU instruction at a time over a valid/ready handshake and reads both operands from an internal 8x16 register file.
- Drives the ALU operand, opcode and out_en inputs through the ALU's two-edge latency, then writes the ALU result back to the register file and latches the ALU flags.
- Strictly serial: one instruction in flight, so there are no hazards.

Parameters:
- NREGS, 8, number of general registers (fixed at 8; sets 3-bit register fields).
- RST_VAL, 16'h0000, reset value of every register-file entry.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- instr  input  16  instruction word: [15:12] opcode, [11] ar_flag, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] reserved.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  block can accept an instruction.
- alu_opcode  output  4  to ALU opcode.
- alu_ar_flag  output  1  to ALU ar_flag.
- alu_src1  output  16  to ALU src1.
- alu_src2  output  16  to ALU src2.
- alu_out_en  output  1  to ALU out_en.
- alu_out  input  16  from ALU out.
- alu_flags  input  4  from ALU flags, {O,C,N,Z}.
- flags  output  4  architectural flags {O,C,N,Z}.
- done  output  1  one-cycle pulse when an instruction retires.
- div0  output  1  one-cycle pulse, coincident with done, on a divide by zero.
- illegal  output  1  one-cycle pulse, coincident with done, on a non-ALU opcode.
- dbg_addr  input  3  debug register select.
- dbg_data  output  16  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all regs=RST_VAL; flags=0.
  - alu_opcode=0, alu_ar_flag=0, alu_src1=0, alu_src2=0, alu_out_en=0.
  - done=div0=illegal=0.
  - Reset mid-instruction abandons it with no writeback.
- All outputs except instr_ready and dbg_data are registered.
- instr_ready = (state==IDLE). The handshake completes on the edge where instr_valid && instr_ready.
- FSM IDLE -> EXEC -> CAPT -> WB -> IDLE.
- IDLE, on accept, registers:
  - alu_opcode and alu_ar_flag from instr.
  - alu_src1 = regs[rs1], alu_src2 = regs[rs2].
  - rd.
- Decode on accept:
  - Legal opcodes are 4'h3..4'hB.
  - Illegal opcodes (0,1,2,C..F) skip directly to WB with no ALU drive; alu_opcode is forced to 0.
  - Divide by zero (opcode 4'h6 with regs[rs2]==0) also skips directly to WB; alu_opcode is forced to 0.
- EXEC: alu_out_en=0; operands held stable. The ALU registers its internal result on this edge.
- CAPT: alu_out_en=1 for exactly this cycle. The ALU registers alu_out and alu_flags on this edge.
- WB, normal case: regs[rd] <= alu_out, flags <= alu_flags, done=1. alu_out_en returns to 0.
- WB, illegal opcode: no register write, flags unchanged, done=1, illegal=1.
- WB, divide by zero: regs[rd] <= 16'hFFFF, flags unchanged, done=1, div0=1.
- Latency: 4 cycles per legal instruction (accept edge to done); 2 cycles for illegal or div0.
- Throughput: at most one instruction per 4 cycles; instr_ready is low during EXEC, CAPT and WB.
- rs1 == rs2 == rd is allowed: operands are read at accept, and the write lands in WB.
- Any register, including r0, is writable; there is no hardwired zero.
- instr_valid while not ready is ignored; the upstream source must hold the instruction until accepted.
- Reserved bits [1:0] are ignored unless the optional feature below is compiled in.

Optional Feature:
- Macro IMM_OPERAND_EN.
- Defined:
  - instr[1]=1 selects an immediate: alu_src2 = zero-extended instr[4:2] (range 0..7) instead of regs[rs2].
  - Divide-by-zero detection uses this immediate value.
  - instr[0] stays reserved.
- Undefined: instr[1:0] are fully ignored and src2 always comes from regs[rs2].

Test Plan:
- Reset, then dbg_addr sweep 0..7 -> every dbg_data=16'h0000; flags=0; instr_ready=1.
- Preload r1=16'h7FFF and r2=16'h0001 via ADD from seeded values, then ADD r3,r1,r2 (opcode 3) -> done 4 cycles after accept; r3=16'h8000; flags=4'b1010 (O=1, N=1).
- SUB r4,r2,r2 (opcode 4) -> r4=16'h0000; flags Z=1. Confirm instr_ready=0 during EXEC/CAPT/WB and alu_out_en high exactly one cycle.
- DIV r5,r1,r0 with r0=0 (opcode 6) -> alu_out_en never asserted; r5=16'hFFFF; div0 and done pulse together 2 cycles after accept; flags unchanged.
- Opcode 4'hE -> illegal=1 and done=1; no register changes; next instruction accepted in IDLE.
- Assert rst=0 during CAPT of ADD r6,r1,r2 -> r6 stays 0; alu_out_en=0 immediately; state IDLE after rst release.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback stage feeding an external two-edge ALU, with an 8x16 register file.
// Latency: accept edge to done is 4 cycles for ALU ops, 2 cycles for illegal opcodes or divide by zero.
// Backpressure: instr_ready is high only in IDLE, so one instruction is in flight. Optional macro IMM_OPERAND_EN enables an immediate src2.
module alu_issue #(
  parameter int          NREGS   = 8,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  alu_opcode,
  output logic        alu_ar_flag,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  output logic        alu_out_en,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  flags,
  output logic        done,
  output logic        div0,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CAPT = 2'd2, WB = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [15:0] regs_q [NREGS];
  logic [3:0]  opcode_q, opcode_d;
  logic        ar_q, ar_d;
  logic [15:0] src1_q, src1_d;
  logic [15:0] src2_q, src2_d;
  logic        out_en_q, out_en_d;
  logic [2:0]  rd_q, rd_d;
  logic        ill_q, ill_d;
  logic        dz_q, dz_d;
  logic [3:0]  flags_q, flags_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;
  logic        illegal_q, illegal_d;
  logic        wr_en;
  logic [15:0] wr_dat;

  // Instruction fields.
  logic [3:0]  op;
  logic [2:0]  rd, rs1, rs2;
  logic        op_legal;
  logic [15:0] src2_val;
  logic        is_dz;
  logic        unused_bits;

  assign op       = instr[15:12];
  assign rd       = instr[10:8];
  assign rs1      = instr[7:5];
  assign rs2      = instr[4:2];
  assign op_legal = (op >= 4'h3) && (op <= 4'hB);
  assign unused_bits = ^instr[1:0];

`ifdef IMM_OPERAND_EN
  // instr[1] picks the zero-extended rs2 field as an immediate operand.
  assign src2_val = instr[1] ? {13'b0, rs2} : regs_q[rs2];
`else
  assign src2_val = regs_q[rs2];
`endif

  // Divide by zero is judged on the operand that would actually reach the ALU.
  assign is_dz = op_legal && (op == 4'h6) && (src2_val == 16'h0000);

  assign instr_ready = (state_q == IDLE);
  assign dbg_data    = regs_q[dbg_addr];

  assign alu_opcode  = opcode_q;
  assign alu_ar_flag = ar_q;
  assign alu_src1    = src1_q;
  assign alu_src2    = src2_q;
  assign alu_out_en  = out_en_q;
  assign flags       = flags_q;
  assign done        = done_q;
  assign div0        = div0_q;
  assign illegal     = illegal_q;

  // Next-state and output decode; skipped instructions never drive the ALU.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    ar_d      = ar_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    out_en_d  = 1'b0;
    rd_d      = rd_q;
    ill_d     = ill_q;
    dz_d      = dz_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    illegal_d = 1'b0;
    wr_en     = 1'b0;
    wr_dat    = alu_out;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          opcode_d = (op_legal && !is_dz) ? op : 4'h0;
          ar_d     = (op_legal && !is_dz) ? instr[11] : 1'b0;
          src1_d   = regs_q[rs1];
          src2_d   = src2_val;
          rd_d     = rd;
          ill_d    = !op_legal;
          dz_d     = is_dz;
          state_d  = (op_legal && !is_dz) ? EXEC : WB;
        end
      end
      EXEC: begin
        out_en_d = 1'b1;
        state_d  = CAPT;
      end
      CAPT: begin
        state_d = WB;
      end
      WB: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (ill_q) begin
          illegal_d = 1'b1;
        end else if (dz_q) begin
          div0_d = 1'b1;
          wr_en  = 1'b1;
          wr_dat = 16'hFFFF;
        end else begin
          wr_en   = 1'b1;
          flags_d = alu_flags;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, ALU drive and status registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      opcode_q  <= 4'h0;
      ar_q      <= 1'b0;
      src1_q    <= 16'h0000;
      src2_q    <= 16'h0000;
      out_en_q  <= 1'b0;
      rd_q      <= 3'd0;
      ill_q     <= 1'b0;
      dz_q      <= 1'b0;
      flags_q   <= 4'h0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      ar_q      <= ar_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      out_en_q  <= out_en_d;
      rd_q      <= rd_d;
      ill_q     <= ill_d;
      dz_q      <= dz_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      illegal_q <= illegal_d;
    end
  end

  // Register file write port, used only in WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RST_VAL;
    end else if (wr_en) begin
      regs_q[rd_q] <= wr_dat;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
`timescale 1ns/1ps
// Bench for alu_issue: a behavioural two-edge ALU, a table of instructions with
// expected results, a scoreboard queue checked when done pulses, and a reset-in-CAPT sequence.
module tb_alu_issue;

  logic        clk, rst;
  logic [15:0] instr;
  logic        instr_valid, instr_ready;
  logic [3:0]  alu_opcode;
  logic        alu_ar_flag;
  logic [15:0] alu_src1, alu_src2;
  logic        alu_out_en;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  flags;
  logic        done, div0, illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_issue dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_opcode(alu_opcode), .alu_ar_flag(alu_ar_flag), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_out_en(alu_out_en), .alu_out(alu_out), .alu_flags(alu_flags), .flags(flags),
    .done(done), .div0(div0), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] exp_rd;
    logic [3:0]  exp_flags;
    logic        exp_div0;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  vec_t        vecs [11];
  vec_t        sb [$];
  logic [15:0] model [8];
  bit          pend = 0;
  int          cnt = 0;
  int          oen_cnt = 0;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic ar,
                                      input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, ar, rd, rs1, rs2, 2'b00};
  endfunction

  // Behavioural ALU: {O,C,N,Z, result}.
  function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, o;
    r = 16'h0; c = 1'b0; o = 1'b0;
    case (op)
      4'h3: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                  o = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h4: begin r = a - b; c = (a < b); o = (a[15] != b[15]) && (r[15] != a[15]); end
      4'h5: r = a & b;
      4'h6: r = (b == 16'h0) ? 16'hFFFF : a / b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'h9: r = a >> 1;
      4'hA: r = a << 1;
      4'hB: r = ~a;
      default: r = 16'h0;
    endcase
    return {o, c, r[15], (r == 16'h0), r};
  endfunction

  // ALU pipeline: internal result every edge, output register loaded when out_en is high.
  logic [19:0] alu_res_q;
  always @(posedge clk) begin
    alu_res_q <= alu_f(alu_opcode, alu_src1, alu_src2);
    if (alu_out_en) begin
      alu_flags <= alu_res_q[19:16];
      alu_out   <= alu_res_q[15:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks the instruction in flight and checks the scoreboard head on done.
  always @(negedge clk) begin
    vec_t cur;
    if (!rst) begin
      pend = 0;
      sb.delete();
    end else begin
      if (pend) begin
        cnt++;
        if (alu_out_en) oen_cnt++;
        if (cnt == 1 && sb.size() > 0) begin
          chk("exec_opcode", {28'h0, alu_opcode}, (sb[0].exp_lat == 4) ? {28'h0, sb[0].ins[15:12]} : 32'h0);
          chk("exec_ar", {31'h0, alu_ar_flag}, (sb[0].exp_lat == 4) ? {31'h0, sb[0].ins[11]} : 32'h0);
        end
        if (done) begin
          pend = 0;
          if (sb.size() == 0) begin
            chk("sb_empty_on_done", 32'd0, 32'd1);
          end else begin
            cur = sb.pop_front();
            chk("latency", cnt, cur.exp_lat);
            chk("div0", {31'h0, div0}, {31'h0, cur.exp_div0});
            chk("illegal", {31'h0, illegal}, {31'h0, cur.exp_ill});
            chk("flags", {28'h0, flags}, {28'h0, cur.exp_flags});
            chk("out_en_cycles", oen_cnt, (cur.exp_lat == 4) ? 1 : 0);
          end
        end else begin
          chk("ready_busy", {31'h0, instr_ready}, 32'h0);
        end
      end else if (done || div0 || illegal) begin
        chk("spurious_pulse", {29'h0, done, div0, illegal}, 32'h0);
      end
      if (instr_valid && instr_ready) begin
        pend = 1; cnt = 0; oen_cnt = 0;
      end
    end
  end

  task automatic send(input vec_t v);
    bit acc;
    acc = 0;
    sb.push_back(v);
    @(posedge clk); #1;
    instr = v.ins;
    instr_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (instr_ready) begin acc = 1; break; end
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    bit got;
    got = 0;
    send(v);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (!pend) begin got = 1; break; end
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      pend = 0;
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (!v.exp_ill) model[v.ins[10:8]] = v.exp_rd;
  endtask

  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("reg%0d", i), {16'h0, dbg_data}, {16'h0, model[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    bit   seen;
    // Regs start at zero; r1 is seeded with 0xFFFF from a divide by zero.
    vecs[0]  = '{enc(4'h6, 1'b0, 3'd1, 3'd0, 3'd0), 16'hFFFF, 4'h0, 1'b1, 1'b0, 2}; // DIV r1,r0,r0 -> div0
    vecs[1]  = '{enc(4'h4, 1'b0, 3'd2, 3'd0, 3'd1), 16'h0001, 4'b0100, 1'b0, 1'b0, 4}; // SUB r2=0-FFFF
    vecs[2]  = '{enc(4'h9, 1'b0, 3'd1, 3'd1, 3'd0), 16'h7FFF, 4'b0000, 1'b0, 1'b0, 4}; // SHR r1
    vecs[3]  = '{enc(4'h3, 1'b1, 3'd3, 3'd1, 3'd2), 16'h8000, 4'b1010, 1'b0, 1'b0, 4}; // ADD r3 overflow
    vecs[4]  = '{enc(4'h4, 1'b0, 3'd4, 3'd2, 3'd2), 16'h0000, 4'b0001, 1'b0, 1'b0, 4}; // SUB r4 zero
    vecs[5]  = '{enc(4'h6, 1'b0, 3'd5, 3'd1, 3'd0), 16'hFFFF, 4'b0001, 1'b1, 1'b0, 2}; // DIV by r0=0
    vecs[6]  = '{enc(4'hE, 1'b0, 3'd6, 3'd1, 3'd2), 16'h0000, 4'b0001, 1'b0, 1'b1, 2}; // illegal E
    vecs[7]  = '{enc(4'h6, 1'b0, 3'd7, 3'd1, 3'd2), 16'h7FFF, 4'b0000, 1'b0, 1'b0, 4}; // DIV 7FFF/1
    vecs[8]  = '{enc(4'h7, 1'b0, 3'd0, 3'd3, 3'd1), 16'hFFFF, 4'b0010, 1'b0, 1'b0, 4}; // OR into r0
    vecs[9]  = '{enc(4'h3, 1'b0, 3'd2, 3'd2, 3'd2), 16'h0002, 4'b0000, 1'b0, 1'b0, 4}; // ADD rd=rs1=rs2
    vecs[10] = '{enc(4'h0, 1'b0, 3'd3, 3'd1, 3'd2), 16'h0000, 4'b0000, 1'b0, 1'b1, 2}; // illegal 0

    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    rst = 1'b0; instr = 16'h0; instr_valid = 1'b0; dbg_addr = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_out_en", {31'h0, alu_out_en}, 32'h0);
    chk("rst_opcode", {28'h0, alu_opcode}, 32'h0);
    chk("rst_done", {29'h0, done, div0, illegal}, 32'h0);
    sweep();

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
      sweep();
    end

    // Reset while the ALU output is being captured: no writeback, back to IDLE.
    rv = '{enc(4'h3, 1'b0, 3'd6, 3'd1, 3'd2), 16'h8001, 4'b1010, 1'b0, 1'b0, 4};
    send(rv);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (alu_out_en) begin seen = 1; break; end
    end
    chk("capt_reached", {31'h0, seen}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_out_en", {31'h0, alu_out_en}, 32'h0);
    chk("rst_mid_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_mid_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("post_rst_flags", {28'h0, flags}, 32'h0);
    sweep();
    rv = '{enc(4'h3, 1'b0, 3'd6, 3'd1, 3'd2), 16'h0000, 4'b0001, 1'b0, 1'b0, 4};
    run_vec(rv);
    sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
